// File: rtl/neuron_seq.sv
// rtl/neuron_seq.sv - gather-buffer consumer: sequences sel, MACs (x,w) pairs, adds bias, saturates
// Optional feature macro: RELU_EN (clamps negative results to zero in DONE)
module neuron_seq #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int N_IN = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] bias,
  output logic [1:0]    sel,
  output logic [DW-1:0] y,
  output logic          done,
  output logic          busy,
  output logic          err
);

  localparam int ACCW = 2*DW + 2;
  localparam logic [1:0] K_LAST = 2'(N_IN);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_DONE} state_t;

  state_t                 state, state_nx;
  logic signed [ACCW-1:0] acc, acc_nx;
  logic [1:0]             k, k_nx;
  logic                   pending, pending_nx;
  logic                   err_nx;
  logic [DW-1:0]          y_nx;

  logic signed [2*DW-1:0] xs, ws, prod, prod_sh;
  logic signed [ACCW-1:0] prod_ext, bias_ext, sum_acc, sum_bias;
  logic [DW-1:0]          sat_v, y_new;

  function automatic logic [DW-1:0] sat(input logic signed [ACCW-1:0] a);
    // In range exactly when every bit above the result's sign bit matches it
    if ((&a[ACCW-1:DW-1]) || !(|a[ACCW-1:DW-1]))
      return a[DW-1:0];
    else if (a[ACCW-1])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  always_comb begin
    xs       = {{DW{x[DW-1]}}, x};
    ws       = {{DW{w[DW-1]}}, w};
    prod     = xs * ws;
    prod_sh  = prod >>> FRAC;
    prod_ext = {{2{prod_sh[2*DW-1]}}, prod_sh};
    bias_ext = {{(ACCW-DW){bias[DW-1]}}, bias};
    sum_acc  = acc + prod_ext;
    sum_bias = acc + bias_ext;
    sat_v    = sat(sum_bias);
`ifdef RELU_EN
    y_new    = sat_v[DW-1] ? '0 : sat_v;
`else
    y_new    = sat_v;
`endif
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    k_nx       = k;
    pending_nx = pending;
    err_nx     = err;
    y_nx       = y;
    sel        = 2'd0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (ready) begin
          acc_nx   = '0;
          k_nx     = 2'd1;
          state_nx = S_ACC;
        end
      end
      S_ACC: begin
        sel    = k;
        acc_nx = sum_acc;
        if (k == K_LAST) state_nx = S_BIAS;
        else             k_nx     = k + 2'd1;
        if (ready) begin
          if (pending) err_nx = 1'b1;
          pending_nx = 1'b1;
        end
      end
      S_BIAS: begin
        acc_nx   = sum_bias;
        y_nx     = y_new;
        state_nx = S_DONE;
        if (ready) begin
          if (pending) err_nx = 1'b1;
          pending_nx = 1'b1;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // A fresh ready coinciding with a held one is a single request
        if (pending || ready) begin
          pending_nx = 1'b0;
          acc_nx     = '0;
          k_nx       = 2'd1;
          state_nx   = S_ACC;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      acc     <= '0;
      k       <= 2'd0;
      pending <= 1'b0;
      err     <= 1'b0;
      y       <= '0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      k       <= k_nx;
      pending <= pending_nx;
      err     <= err_nx;
      y       <= y_nx;
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// tb/tb_neuron_seq.sv - scoreboard bench for neuron_seq with a behavioural reference model
module tb_neuron_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [15:0] x, w, bias;
  logic [1:0]  sel;
  logic [15:0] y;
  logic        done, busy, err;

  neuron_seq #(.DW(16), .FRAC(8), .N_IN(3)) dut (
    .clk(clk), .reset(reset), .ready(ready), .x(x), .w(w), .bias(bias),
    .sel(sel), .y(y), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] dx[0:255][0:2];
  logic [15:0] dw[0:255][0:2];
  logic [15:0] db[0:255];
  int          n_issued = 0;
  int          cur = 0;
  int          cyc = 0;
  int          last_done = -1000;
  logic        err_exp = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: sum of per-pair products (each truncated toward -inf by the Q shift),
  // plus bias, clamped to the 16-bit signed range
  function automatic logic [15:0] ref_y(input int n);
    longint s = 0;
    for (int i = 0; i < 3; i++)
      s += (longint'($signed(dx[n][i])) * longint'($signed(dw[n][i]))) >>> 8;
    s += longint'($signed(db[n]));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  // Buffer model: presents the pair chosen by sel for the neuron being consumed
  always @(posedge clk) begin
    #2;
    if (done === 1'b1) cur++;
    if (sel != 2'd0) begin
      x = dx[cur][sel-1];
      w = dw[cur][sel-1];
    end else begin
      x = 16'($urandom);
      w = 16'($urandom);
    end
    bias = db[cur];
  end

  // Monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y", 32'(y), 32'(e.y));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("err", 32'(err), 32'(err_exp));
      end
    end
  end

  task automatic set_data(input logic [15:0] x0, x1, x2, w0, w1, w2, b);
    dx[n_issued][0] = x0; dx[n_issued][1] = x1; dx[n_issued][2] = x2;
    dw[n_issued][0] = w0; dw[n_issued][1] = w1; dw[n_issued][2] = w2;
    db[n_issued]    = b;
  endtask

  // One-cycle ready pulse; when push is set the neuron is expected to complete
  // five cycles after it can start (its own pulse or the previous done)
  task automatic fire(input bit push, input logic [15:0] ey);
    if (push) begin
      exp_t e;
      int start;
      start = (cyc > last_done) ? cyc : last_done;
      e.y = ey;
      e.cyc = start + 5;
      last_done = e.cyc;
      q.push_back(e);
      n_issued++;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || busy !== 1'b0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wait_idle_timeout", 32'(t >= 300), 32'd0);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // 1: basic MAC and sel timing
    set_data(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0000);
    fire(1'b1, 16'h0600);
    @(negedge clk); chk("t1_sel1", 32'(sel), 32'd1);
    @(negedge clk); chk("t1_sel2", 32'(sel), 32'd2);
    @(negedge clk); chk("t1_sel3", 32'(sel), 32'd3);
    @(negedge clk); chk("t1_bias_sel", 32'(sel), 32'd0);
    chk("t1_bias_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    wait_idle();

    // 2: saturate high
    set_data(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7FFF);
    fire(1'b1, 16'h7FFF);
    wait_idle();

    // 3: negative result
    set_data(16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0000);
`ifdef RELU_EN
    fire(1'b1, 16'h0000);
`else
    fire(1'b1, 16'hFD00);
`endif
    wait_idle();

    // 4: second pulse while busy is held and served back to back
    set_data(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0000);
    fire(1'b1, 16'h0600);
    idle(1);
    set_data(16'h0200, 16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    fire(1'b1, 16'h0700);
    wait_idle();

    // 5: third pulse overflows the one-deep pending slot
    set_data(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0000);
    fire(1'b1, 16'h0600);
    idle(1);
    set_data(16'h0080, 16'h0080, 16'h0080, 16'h0400, 16'h0400, 16'h0400, 16'hFF00);
    fire(1'b1, 16'h0500);
    err_exp = 1'b1;
    fire(1'b0, 16'h0000);
    wait_idle();
    set_data(16'h0100, 16'h0000, 16'h0000, 16'h0300, 16'h0000, 16'h0000, 16'h0000);
    fire(1'b1, 16'h0300);
    wait_idle();
    chk("t5_err_held", 32'(err), 32'd1);

    // 6: reset aborts a neuron in flight
    set_data(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0000);
    fire(1'b0, 16'h0000);
    idle(1);
    reset = 1'b1;
    err_exp = 1'b0;
    last_done = -1000;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_sel", 32'(sel), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_y", 32'(y), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    idle(12);

    // Randomized traffic, spaced so no pulse is ever lost
    for (int i = 0; i < 24; i++) begin
      set_data(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
      fire(1'b1, ref_y(n_issued));
      idle($urandom_range(4, 8));
    end
    wait_idle();
    chk("final_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
